dual_rail_capture: RTL and testbench
====================================

Name: dual_rail_capture

Overview:
- Downstream consumer of complementary-pair (dual-rail) gate netlists; each logical bit arrives as a true/false rail pair, e.g. y/ybar.
- Sequences the upstream logic through precharge (spacer, both rails 0) and evaluate phases.
- Detects completion when every pair holds a valid code word, captures the single-rail result, and presents it on a valid/ready handshake.
- Flags invalid code words (both rails 1) and phase timeouts.

Parameters:
- WIDTH, 4, number of dual-rail bit pairs consumed.
- TIMEOUT, 15, max cycles allowed in PRECHARGE or EVALUATE before error; legal range 2..255.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request one evaluation; sampled only in IDLE.
- d_t  in  WIDTH  true rails from upstream dual-rail logic.
- d_f  in  WIDTH  false rails (d_f[i] pairs with d_t[i]).
- out_ready  in  1  downstream accepts q.
- clr_err  in  1  leave ERROR; sampled only in ERROR.
- precharge  out  1  forces upstream inputs to spacer while high.
- q  out  WIDTH  captured single-rail result (= d_t at completion).
- out_valid  out  1  q is valid.
- busy  out  1  high in any state except IDLE.
- err_flag  out  1  high while in ERROR.
- err_code  out  2  00 none, 01 invalid code word (11), 10 evaluate timeout, 11 precharge timeout.

Behaviour:
- Clock and reset:
  - One clock domain; all outputs registered.
  - d_t/d_f are registered once (t_r/f_r); all decisions use t_r/f_r, so there is a 1-cycle observation lag.
  - rst at any time, mid-operation included: state=IDLE, precharge=0, q=0, out_valid=0, busy=0, err_flag=0, err_code=00, counter=0, t_r/f_r=0.
- Predicates on registered rails:
  - spacer = all pairs 00.
  - complete = every pair 01 or 10.
  - bad = any pair 11.
- States: IDLE, PRECHARGE, EVALUATE, HOLD, ERROR.
- IDLE:
  - start=1 -> PRECHARGE next cycle; precharge=1 from that cycle.
  - Otherwise stay.
- PRECHARGE (precharge=1):
  - Counter cleared on entry, +1 per cycle.
  - Priority: bad -> ERROR/01; else spacer -> EVALUATE (precharge=0 next cycle); else counter==TIMEOUT-1 -> ERROR/11; else stay.
- EVALUATE (precharge=0):
  - Counter cleared on entry.
  - Priority: bad -> ERROR/01; else complete -> HOLD with q<=t_r and out_valid=1 next cycle; else counter==TIMEOUT-1 -> ERROR/10; else stay.
  - Partially valid words (some pairs still 00) are not errors.
- HOLD:
  - out_valid=1; q stable until transfer.
  - out_valid&out_ready -> IDLE and out_valid=0 next cycle.
  - Input changes are ignored; a new start cannot be accepted until IDLE.
- ERROR:
  - err_flag=1; err_code holds the cause; precharge=0; out_valid=0; q keeps its old value.
  - clr_err=1 -> IDLE with err_flag=0, err_code=00.
  - Start is ignored.
- Simultaneous events:
  - Completion and timeout on the same edge -> completion wins.
  - bad beats everything.
  - rst beats clr_err and start.
- Counter: width clog2(TIMEOUT+1); saturates, never wraps.
- Minimum latency: start sampled at edge 0 -> out_valid at edge 4, given the spacer is already present and valid data arrives 1 cycle after precharge falls.

Test Plan:
- Nominal, WIDTH=4, TIMEOUT=15: start pulse; upstream gives spacer 1 cycle after precharge rises, then d_t=1010 / d_f=0101 2 cycles after precharge falls; out_ready=1 -> q=1010, out_valid high exactly 1 cycle, busy returns to 0, err_code=00.
- Backpressure: same data with out_ready low 5 cycles -> out_valid and q=1010 held 5 cycles; rail changes to 0110/1001 during HOLD leave q unchanged; transfer on the 6th cycle.
- Invalid word: during EVALUATE drive d_t=0100, d_f=0100 -> ERROR, err_flag=1, err_code=01, out_valid stays 0; clr_err pulse -> IDLE, err_flag=0.
- Evaluate timeout: spacer given, rails held 00 -> ERROR/10 exactly 15 cycles after EVALUATE entry; completion arriving on that same edge -> HOLD, no error.
- Precharge timeout: rails stuck 0001/1110 -> ERROR/11 after 15 PRECHARGE cycles, precharge drops to 0.
- Reset mid-EVALUATE: rst=1 for 1 cycle -> all outputs at reset values on the next cycle; start is ignored during rst; the next start runs a normal evaluation.

Source files
------------

// File: rtl/dual_rail_capture.sv
// Completion detector and capture stage for dual-rail (true/false rail) logic.
// Drives precharge/evaluate phases upstream and hands the single-rail result off on valid/ready.

module dr_pair (
   input  logic t,
   input  logic f,
   output logic sp,
   output logic ok,
   output logic bad
);
   assign sp  = ~t & ~f;
   assign ok  = t ^ f;
   assign bad = t & f;
endmodule

module dual_rail_capture #(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] d_t,
   input  logic [WIDTH-1:0] d_f,
   input  logic             out_ready,
   input  logic             clr_err,
   output logic             precharge,
   output logic [WIDTH-1:0] q,
   output logic             out_valid,
   output logic             busy,
   output logic             err_flag,
   output logic [1:0]       err_code
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_EVAL, S_HOLD, S_ERR} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] t_r, f_r;
   logic [WIDTH-1:0] pair_sp, pair_ok, pair_bad;
   logic [CW-1:0]    cnt;
   logic [1:0]       code_n;
   logic             cap;
   logic             spacer, complete, bad;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_pair
         dr_pair u_pair (
            .t   (t_r[i]),
            .f   (f_r[i]),
            .sp  (pair_sp[i]),
            .ok  (pair_ok[i]),
            .bad (pair_bad[i])
         );
      end
   endgenerate

   assign spacer   = &pair_sp;
   assign complete = &pair_ok;
   assign bad      = |pair_bad;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // bad outranks everything; completion outranks a timeout on the same edge
   always_comb begin
      state_n = state;
      code_n  = err_code;
      cap     = 1'b0;
      case (state)
         S_IDLE: if (start) state_n = S_PRE;
         S_PRE: begin
            if (bad)                 begin state_n = S_ERR; code_n = 2'b01; end
            else if (spacer)         state_n = S_EVAL;
            else if (cnt == CNT_LIM) begin state_n = S_ERR; code_n = 2'b11; end
         end
         S_EVAL: begin
            if (bad)                 begin state_n = S_ERR; code_n = 2'b01; end
            else if (complete)       begin state_n = S_HOLD; cap = 1'b1; end
            else if (cnt == CNT_LIM) begin state_n = S_ERR; code_n = 2'b10; end
         end
         S_HOLD: if (out_ready) state_n = S_IDLE;
         S_ERR: if (clr_err) begin state_n = S_IDLE; code_n = 2'b00; end
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         t_r       <= '0;
         f_r       <= '0;
         cnt       <= '0;
         q         <= '0;
         precharge <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         err_flag  <= 1'b0;
         err_code  <= 2'b00;
      end else begin
         t_r       <= d_t;
         f_r       <= d_f;
         if (state_n != state || (state_n != S_PRE && state_n != S_EVAL))
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
         if (cap) q <= t_r;
         precharge <= (state_n == S_PRE);
         out_valid <= (state_n == S_HOLD);
         busy      <= (state_n != S_IDLE);
         err_flag  <= (state_n == S_ERR);
         err_code  <= code_n;
      end
   end
endmodule

// File: tb/tb_dual_rail_capture.sv
// Directed bench for dual_rail_capture; a scoreboard queue holds expected q words
// and a negedge monitor checks every handshake transfer against it.

module tb_dual_rail_capture;
   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst, start, out_ready, clr_err;
   logic [WIDTH-1:0] d_t, d_f;
   logic             precharge, out_valid, busy, err_flag;
   logic [WIDTH-1:0] q;
   logic [1:0]       err_code;

   int checks   = 0;
   int failures = 0;
   logic [WIDTH-1:0] sb[$];

   dual_rail_capture #(.WIDTH(WIDTH), .TIMEOUT(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .d_t       (d_t),
      .d_f       (d_f),
      .out_ready (out_ready),
      .clr_err   (clr_err),
      .precharge (precharge),
      .q         (q),
      .out_valid (out_valid),
      .busy      (busy),
      .err_flag  (err_flag),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rails(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] f);
      d_t = t;
      d_f = f;
   endtask

   // start pulse sampled in IDLE, then one edge in PRECHARGE with spacer present
   task automatic begin_eval;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("pre_rise", precharge, 1);
      tick();
      chk("pre_fall", precharge, 0);
   endtask

   task automatic clear_error;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_flag", err_flag, 0);
      chk("clr_code", err_code, 0);
      chk("clr_busy", busy, 0);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got q=%0h with no expected word", q);
         end else begin
            chk("sb_q", q, sb.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
      rails(4'b0000, 4'b0000);
      tick(); tick();
      chk("rst_pre", precharge, 0);
      chk("rst_q", q, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_flag, 0);
      chk("rst_code", err_code, 0);
      rst = 1'b0;
      tick();

      // nominal, minimum latency: out_valid appears 4 edges after start
      begin_eval();
      tick();
      rails(4'b1010, 4'b0101);
      sb.push_back(4'b1010);
      tick();
      chk("nom_early", out_valid, 0);
      tick();
      chk("nom_valid", out_valid, 1);
      chk("nom_q", q, 4'b1010);
      tick();
      chk("nom_drop", out_valid, 0);
      chk("nom_busy", busy, 0);
      chk("nom_code", err_code, 0);
      rails(4'b0000, 4'b0000);
      tick();

      // backpressure: HOLD for 5 cycles, rails and start ignored meanwhile
      out_ready = 1'b0;
      begin_eval();
      tick();
      rails(4'b1010, 4'b0101);
      sb.push_back(4'b1010);
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", out_valid, 1);
         chk("bp_q", q, 4'b1010);
         if (i == 1) rails(4'b0110, 4'b1001);
         start = (i == 2);
         tick();
      end
      out_ready = 1'b1;
      chk("bp_valid6", out_valid, 1);
      tick();
      chk("bp_drop", out_valid, 0);
      chk("bp_busy", busy, 0);
      rails(4'b0000, 4'b0000);
      tick();

      // invalid code word during EVALUATE
      begin_eval();
      rails(4'b0100, 4'b0100);
      tick(); tick();
      chk("bad_flag", err_flag, 1);
      chk("bad_code", err_code, 2'b01);
      chk("bad_valid", out_valid, 0);
      chk("bad_pre", precharge, 0);
      chk("bad_qkeep", q, 4'b1010);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("bad_stay", err_flag, 1);
      rails(4'b0000, 4'b0000);
      clear_error();

      // evaluate timeout: error exactly 15 edges after EVALUATE entry
      begin_eval();
      repeat (14) tick();
      chk("evto_before", err_flag, 0);
      tick();
      chk("evto_flag", err_flag, 1);
      chk("evto_code", err_code, 2'b10);
      clear_error();

      // completion on the timeout edge wins
      begin_eval();
      repeat (13) tick();
      rails(4'b0011, 4'b1100);
      sb.push_back(4'b0011);
      tick();
      chk("race_early", out_valid, 0);
      tick();
      chk("race_valid", out_valid, 1);
      chk("race_noerr", err_flag, 0);
      chk("race_q", q, 4'b0011);
      tick();
      rails(4'b0000, 4'b0000);
      tick();

      // precharge timeout with rails stuck at a non-spacer word
      rails(4'b0001, 4'b1110);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (14) tick();
      chk("prto_before", precharge, 1);
      chk("prto_noerr", err_flag, 0);
      tick();
      chk("prto_flag", err_flag, 1);
      chk("prto_code", err_code, 2'b11);
      chk("prto_pre", precharge, 0);
      rails(4'b0000, 4'b0000);
      clear_error();

      // reset mid-EVALUATE beats a concurrent start
      begin_eval();
      tick(); tick();
      rst = 1'b1; start = 1'b1;
      tick();
      chk("mrst_pre", precharge, 0);
      chk("mrst_q", q, 0);
      chk("mrst_valid", out_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_err", err_flag, 0);
      chk("mrst_code", err_code, 0);
      rst = 1'b0; start = 1'b0;
      tick();
      chk("mrst_idle", busy, 0);
      begin_eval();
      tick();
      rails(4'b1100, 4'b0011);
      sb.push_back(4'b1100);
      tick(); tick();
      chk("post_valid", out_valid, 1);
      chk("post_q", q, 4'b1100);
      tick();
      chk("post_busy", busy, 0);
      rails(4'b0000, 4'b0000);
      tick(); tick();

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
